// File: rtl/cpu_pkg.sv
// Shared constants, field widths and FSM state type for the 4-bit CPU controller.
package cpu_pkg;

  localparam int unsigned DATA_W    = 4;
  localparam int unsigned PC_W      = 4;
  localparam int unsigned INSTR_W   = 8;
  localparam int unsigned REG_IDX_W = 2;
  localparam int unsigned NUM_REGS  = 4;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] CLS_ALU  = 2'b00;
  localparam logic [1:0] CLS_LDI  = 2'b01;
  localparam logic [1:0] CLS_JMP  = 2'b10;
  localparam logic [1:0] CLS_HALT = 2'b11;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    HALT   = 2'b11
  } state_e;

  function automatic logic [1:0] instr_class(input logic [INSTR_W-1:0] instr);
    return instr[7:6];
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 4x4-bit register file: one synchronous write port, three combinational read ports.
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr_a,
  input  logic [REG_IDX_W-1:0] i_raddr_b,
  input  logic [REG_IDX_W-1:0] i_raddr_dbg,
  output logic [DATA_W-1:0]    o_rdata_a,
  output logic [DATA_W-1:0]    o_rdata_b,
  output logic [DATA_W-1:0]    o_rdata_dbg
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a   = r_regs[i_raddr_a];
  assign o_rdata_b   = r_regs[i_raddr_b];
  assign o_rdata_dbg = r_regs[i_raddr_dbg];

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute controller driving an external combinational ALU.
module cpu_control_unit
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req,
  output logic [PC_W-1:0]      imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  output logic [1:0]           alu_control,
  input  logic [DATA_W-1:0]    alu_result,
  output logic [PC_W-1:0]      pc,
  output logic                 halted,
  input  logic [REG_IDX_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]    dbg_data
);

  state_e             r_state, w_state_next;
  logic [PC_W-1:0]    r_pc, w_pc_next;
  logic [INSTR_W-1:0] r_ir, w_ir_next;
  logic               r_req, w_req_next;
  logic [DATA_W-1:0]  r_alu_a, w_alu_a_next;
  logic [DATA_W-1:0]  r_alu_b, w_alu_b_next;
  logic [1:0]         r_alu_ctl, w_alu_ctl_next;

  logic                 w_we;
  logic [REG_IDX_W-1:0] w_waddr;
  logic [DATA_W-1:0]    w_wdata;
  logic [DATA_W-1:0]    w_rdata_a;
  logic [DATA_W-1:0]    w_rdata_b;
  logic [REG_IDX_W-1:0] w_rd;
  logic [REG_IDX_W-1:0] w_rs;

  // ALU-class field positions; rd doubles as operand A source and writeback target.
  assign w_rd = r_ir[3:2];
  assign w_rs = r_ir[1:0];

  cpu_regfile u_regfile (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_we        (w_we),
    .i_waddr     (w_waddr),
    .i_wdata     (w_wdata),
    .i_raddr_a   (w_rd),
    .i_raddr_b   (w_rs),
    .i_raddr_dbg (dbg_sel),
    .o_rdata_a   (w_rdata_a),
    .o_rdata_b   (w_rdata_b),
    .o_rdata_dbg (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_pc      <= '0;
      r_ir      <= '0;
      r_req     <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_ctl <= ALU_ADD;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_ir      <= w_ir_next;
      r_req     <= w_req_next;
      r_alu_a   <= w_alu_a_next;
      r_alu_b   <= w_alu_b_next;
      r_alu_ctl <= w_alu_ctl_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_ir_next      = r_ir;
    w_req_next     = r_req;
    w_alu_a_next   = r_alu_a;
    w_alu_b_next   = r_alu_b;
    w_alu_ctl_next = r_alu_ctl;
    w_we           = 1'b0;
    w_waddr        = w_rd;
    w_wdata        = alu_result;

    unique case (r_state)
      FETCH: begin
        if (!r_req) begin
          w_req_next = 1'b1;
        end else if (imem_ack) begin
          w_ir_next    = imem_data;
          w_req_next   = 1'b0;
          w_state_next = DECODE;
        end
      end
      DECODE: begin
        unique case (instr_class(r_ir))
          CLS_ALU: begin
            w_alu_a_next   = w_rdata_a;
            w_alu_b_next   = w_rdata_b;
            w_alu_ctl_next = r_ir[5:4];
            w_state_next   = EXEC;
          end
          CLS_LDI: begin
            w_we         = 1'b1;
            w_waddr      = r_ir[5:4];
            w_wdata      = r_ir[3:0];
            w_pc_next    = r_pc + PC_W'(1);
            w_state_next = FETCH;
          end
          CLS_JMP: begin
            w_pc_next    = r_ir[3:0];
            w_state_next = FETCH;
          end
          CLS_HALT: begin
            w_state_next = HALT;
          end
          default: begin
            w_state_next = HALT;
          end
        endcase
      end
      EXEC: begin
        w_we         = 1'b1;
        w_pc_next    = r_pc + PC_W'(1);
        w_state_next = FETCH;
      end
      HALT: begin
        w_state_next = HALT;
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_control = r_alu_ctl;
  assign halted      = (r_state == HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench: expected fetches/register values and ALU operands are queued, a monitor pops them.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [1:0] alu_control;
  logic [3:0] alu_result;
  logic [3:0] pc;
  logic       halted;
  logic [1:0] dbg_sel = 2'd0;
  logic [3:0] dbg_data;

  logic [7:0] imem [16];

  typedef struct {
    logic [3:0] addr;
    logic [1:0] sel;
    logic [3:0] val;
  } fetch_exp_t;

  typedef struct {
    logic [1:0] ctl;
    logic [3:0] a;
    logic [3:0] b;
  } alu_exp_t;

  fetch_exp_t fq[$];
  alu_exp_t   aq[$];

  int n_checks = 0;
  int n_pass   = 0;
  logic prev_req = 1'b0;
  int exec_cnt = 0;

  cpu_control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .pc          (pc),
    .halted      (halted),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  always_comb begin
    alu_result = 4'h0;
    case (alu_control)
      2'b00: alu_result = alu_a + alu_b;
      2'b01: alu_result = alu_a | alu_b;
      2'b10: alu_result = alu_a ^ alu_b;
      default: alu_result = ~alu_a;
    endcase
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_f(input logic [3:0] a, input logic [1:0] s, input logic [3:0] v);
    fetch_exp_t e;
    e.addr = a; e.sel = s; e.val = v;
    fq.push_back(e);
  endtask

  task automatic push_a(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
    alu_exp_t e;
    e.ctl = c; e.a = a; e.b = b;
    aq.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while ((fq.size() != 0 || aq.size() != 0) && i < budget) begin
      @(negedge clk);
      #3;
      i++;
    end
    if (fq.size() != 0 || aq.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d fetches and %0d alu ops pending, expected 0",
               fq.size(), aq.size());
      fq.delete();
      aq.delete();
    end
  endtask

  // Monitor: a rising imem_req presents a new fetch; EXEC is two cycles after an ALU handshake.
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      prev_req = 1'b0;
      exec_cnt = 0;
    end else begin
      if (exec_cnt > 0) begin
        exec_cnt--;
        if (exec_cnt == 0) begin
          if (aq.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_exec: got ctl %0h, expected no ALU op", alu_control);
          end else begin
            alu_exp_t ae;
            ae = aq.pop_front();
            chk("exec_alu_control", {6'd0, alu_control}, {6'd0, ae.ctl});
            chk("exec_alu_a", {4'd0, alu_a}, {4'd0, ae.a});
            chk("exec_alu_b", {4'd0, alu_b}, {4'd0, ae.b});
          end
        end
      end
      if (imem_req && !prev_req) begin
        if (fq.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_fetch: got addr 0x%0h, expected no fetch", imem_addr);
        end else begin
          fetch_exp_t fe;
          fe = fq.pop_front();
          chk("fetch_addr", {4'd0, imem_addr}, {4'd0, fe.addr});
          dbg_sel = fe.sel;
          #1;
          chk("fetch_reg", {4'd0, dbg_data}, {4'd0, fe.val});
        end
      end
      if (imem_req && imem_ack && imem_data[7:6] == 2'b00) exec_cnt = 2;
      prev_req = imem_req;
    end
  end

  initial begin
    logic found;
    logic ok;
    imem_ack = 1'b1;
    for (int i = 0; i < 16; i++) imem[i] = 8'hC0;
    imem[0]  = 8'h45; // LDI r0,5
    imem[1]  = 8'h53; // LDI r1,3
    imem[2]  = 8'h01; // ADD r0,r1
    imem[3]  = 8'h6A; // LDI r2,A
    imem[4]  = 8'h56; // LDI r1,6
    imem[5]  = 8'h29; // XOR r2,r1
    imem[6]  = 8'h7F; // LDI r3,F
    imem[7]  = 8'h0F; // ADD r3,r3
    imem[8]  = 8'h8C; // JMP 12
    imem[12] = 8'h16; // OR r1,r2
    imem[13] = 8'h30; // NOT r0
    imem[14] = 8'hB9; // JMP 9, ignored bits set
    imem[9]  = 8'hC0; // HALT

    push_f(4'd0,  2'd0, 4'h0);
    push_f(4'd1,  2'd0, 4'h5);
    push_f(4'd2,  2'd1, 4'h3);
    push_f(4'd3,  2'd0, 4'h8);
    push_f(4'd4,  2'd2, 4'hA);
    push_f(4'd5,  2'd1, 4'h6);
    push_f(4'd6,  2'd2, 4'hC);
    push_f(4'd7,  2'd3, 4'hF);
    push_f(4'd8,  2'd3, 4'hE);
    push_f(4'd12, 2'd0, 4'h8);
    push_f(4'd13, 2'd1, 4'hE);
    push_f(4'd14, 2'd0, 4'h7);
    push_f(4'd9,  2'd2, 4'hC);
    push_a(2'b00, 4'h5, 4'h3);
    push_a(2'b10, 4'hA, 4'h6);
    push_a(2'b00, 4'hF, 4'hF);
    push_a(2'b01, 4'h6, 4'hC);
    push_a(2'b11, 4'h8, 4'h8);

    #1;
    chk("rst_imem_req", {7'd0, imem_req}, 8'd0);
    chk("rst_pc", {4'd0, pc}, 8'd0);
    chk("rst_alu_a", {4'd0, alu_a}, 8'd0);
    chk("rst_alu_b", {4'd0, alu_b}, 8'd0);
    chk("rst_alu_control", {6'd0, alu_control}, 8'd0);
    chk("rst_halted", {7'd0, halted}, 8'd0);
    chk("rst_dbg_data", {4'd0, dbg_data}, 8'd0);

    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (11) @(posedge clk);
    #1 chk("pc_after_11_cycles", {4'd0, pc}, 8'd3);

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (imem_req && imem_addr == 4'd5) found = 1'b1;
    end
    chk("stall_fetch_reached", {7'd0, found}, 8'd1);
    imem_ack = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(imem_req === 1'b1 && imem_addr === 4'd5)) ok = 1'b0;
    end
    imem_ack = 1'b1;
    chk("stall_req_addr_stable", {7'd0, ok}, 8'd1);

    wait_drain(300);
    repeat (6) @(negedge clk);
    chk("halt_halted", {7'd0, halted}, 8'd1);
    chk("halt_pc", {4'd0, pc}, 8'd9);
    ok = 1'b1;
    repeat (24) begin
      @(negedge clk);
      if (imem_req !== 1'b0) ok = 1'b0;
    end
    chk("halt_no_fetch", {7'd0, ok}, 8'd1);

    // Reset out of HALT with non-zero ALU operands and registers.
    rst_n = 1'b0;
    #1;
    chk("rst2_halted", {7'd0, halted}, 8'd0);
    chk("rst2_pc", {4'd0, pc}, 8'd0);
    chk("rst2_alu_a", {4'd0, alu_a}, 8'd0);
    chk("rst2_alu_b", {4'd0, alu_b}, 8'd0);
    chk("rst2_alu_control", {6'd0, alu_control}, 8'd0);
    chk("rst2_dbg_data", {4'd0, dbg_data}, 8'd0);

    for (int i = 0; i < 16; i++) imem[i] = 8'hC0;
    imem[0]  = 8'h8F; // JMP 15
    imem[15] = 8'h63; // LDI r2,3, pc wraps to 0
    push_f(4'd0,  2'd0, 4'h0);
    push_f(4'd15, 2'd2, 4'h0);
    push_f(4'd0,  2'd2, 4'h3);
    push_f(4'd15, 2'd2, 4'h3);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    wait_drain(100);
    chk("pre_reset_req", {7'd0, imem_req}, 8'd1);
    chk("pre_reset_addr", {4'd0, imem_addr}, 8'd15);

    rst_n = 1'b0;
    #1;
    chk("rst3_imem_req", {7'd0, imem_req}, 8'd0);
    chk("rst3_pc", {4'd0, pc}, 8'd0);
    chk("rst3_imem_addr", {4'd0, imem_addr}, 8'd0);
    chk("rst3_dbg_data", {4'd0, dbg_data}, 8'd0);
    push_f(4'd0, 2'd2, 4'h0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    wait_drain(50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
